// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: transmit byte queue plus launch controller
// feeding a UART transmitter over data_in/tx_start/tx_busy.
module uart_tx_fifo #(
  parameter int DEPTH       = 16,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     flush,
  input  logic                     clr_ovf,
  input  logic                     tx_busy,
  output logic [7:0]               tx_data,
  output logic                     tx_start,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     retry
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] FULLV = CW'(DEPTH);
  localparam logic [TW-1:0] TMAX  = TW'(ACK_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          start_q, start_d;
  logic          full_q, empty_q;
  logic          ovf_q, ovf_d;
  logic          retry_q, retry_d;
  logic          pend_q, pend_d;
  logic          wr_acc, pop, is_full;

  assign is_full = (count_q == FULLV);
  assign wr_acc  = wr_en && !is_full && !flush;

  // Launch FSM: pop, pulse tx_start, await busy, then a low gap.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    pend_d  = pend_q;
    retry_d = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!tx_busy) begin
          if (pend_q) begin
            pend_d  = 1'b0;
            state_d = LAUNCH;
          end else if (count_q != '0 && !flush) begin
            pop     = 1'b1;
            state_d = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        tmo_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (tmo_q == TMAX) begin
          retry_d = 1'b1;
          pend_d  = 1'b1;
          state_d = GAP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = GAP;
      end
      GAP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Queue bookkeeping; flush wins over a concurrent write.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    tx_data_d = tx_data_q;
    ovf_d     = ovf_q;
    if (pop) tx_data_d = mem_q[rd_ptr_q];
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_acc && !pop) count_d = count_q + 1'b1;
      if (!wr_acc && pop) count_d = count_q - 1'b1;
    end
    if (clr_ovf) ovf_d = 1'b0;
    if (wr_en && is_full) ovf_d = 1'b1;
    start_d = (state_d == LAUNCH);
  end

  // Byte storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tmo_q     <= '0;
      tx_data_q <= '0;
      start_q   <= 1'b0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ovf_q     <= 1'b0;
      retry_q   <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tmo_q     <= tmo_d;
      tx_data_q <= tx_data_d;
      start_q   <= start_d;
      full_q    <= (count_d == FULLV);
      empty_q   <= (count_d == '0);
      ovf_q     <= ovf_d;
      retry_q   <= retry_d;
      pend_q    <= pend_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_start = start_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = ovf_q;
  assign retry    = retry_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of uart_tx_fifo
// against a simple busy/frame transmitter model.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       flush = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       retry;

  logic       xm_en = 1'b1;
  logic       busy_force = 1'b0;
  int         bcnt = 0;
  logic       prev_s = 1'b0;
  logic       prev_b = 1'b0;
  int         viol = 0;
  logic [7:0] log_q [$];

  int n_cmp = 0;
  int n_bad = 0;
  int base;
  int n;

  uart_tx_fifo #(.DEPTH(16), .ACK_TIMEOUT(15)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .flush    (flush),
    .clr_ovf  (clr_ovf),
    .tx_busy  (tx_busy),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .retry    (retry)
  );

  always #5 clk = ~clk;

  assign tx_busy = xm_en ? (bcnt != 0) : busy_force;

  // Transmitter model: logs each launch, busy for 8 cycles.
  always @(posedge clk) begin
    if (tx_start) begin
      log_q.push_back(tx_data);
      if (prev_s || prev_b) viol++;
    end
    prev_s <= tx_start;
    prev_b <= tx_busy;
    if (xm_en) begin
      if (tx_start)       bcnt <= 8;
      else if (bcnt != 0) bcnt <= bcnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin
    tick(2);
    chk("rst_data", tx_data, 8'h00);
    chk("rst_start", tx_start, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_count", count, 5'd0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_retry", retry, 1'b0);
    rst_n = 1'b1;
    tick();

    // single byte: visible next cycle, launched two cycles after write
    wr_en = 1'b1;
    wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    chk("t1_count", count, 5'd1);
    chk("t1_empty", empty, 1'b0);
    tick();
    chk("t1_start", tx_start, 1'b1);
    chk("t1_data", tx_data, 8'hA5);
    chk("t1_cnt0", count, 5'd0);
    tick();
    chk("t1_pulse", tx_start, 1'b0);
    tick(20);
    chk("t1_log", log_q[0], 8'hA5);

    // fill while transmitter busy, then overflow
    xm_en = 1'b0;
    busy_force = 1'b1;
    for (int i = 1; i <= 16; i++) wr(8'(i));
    chk("t2_count", count, 5'd16);
    chk("t2_full", full, 1'b1);
    chk("t2_noovf", overflow, 1'b0);
    wr(8'h11);
    chk("t2_ovf", overflow, 1'b1);
    chk("t2_cnt16", count, 5'd16);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t2_clrovf", overflow, 1'b0);

    // drain back-to-back through the transmitter model
    xm_en = 1'b1;
    n = 0;
    while (log_q.size() < 17 && n < 400) begin
      tick();
      n++;
    end
    chk("t3_drain", log_q.size(), 17);
    for (int i = 1; i <= 16; i++) begin
      if (i < log_q.size()) chk("t3_order", log_q[i], i);
    end
    tick(15);
    chk("t3_empty", empty, 1'b1);
    chk("t3_full", full, 1'b0);

    // no busy response: timeout, retry, same byte relaunched
    xm_en = 1'b0;
    busy_force = 1'b0;
    base = log_q.size();
    wr(8'h5A);
    tick();
    chk("t4_start", tx_start, 1'b1);
    n = 0;
    while (!retry && n < 40) begin
      tick();
      n++;
    end
    chk("t4_retry_lat", n, 17);
    chk("t4_data", tx_data, 8'h5A);
    tick();
    chk("t4_retry_pulse", retry, 1'b0);
    n = 0;
    while (!tx_start && n < 10) begin
      tick();
      n++;
    end
    chk("t4_relaunch", tx_start, 1'b1);
    chk("t4_redata", tx_data, 8'h5A);
    tick();
    busy_force = 1'b1;
    tick(3);
    busy_force = 1'b0;
    tick(4);
    chk("t4_logn", log_q.size(), base + 2);
    if (log_q.size() >= base + 2) chk("t4_logd", log_q[base+1], 8'h5A);

    // flush with five queued and one in flight
    xm_en = 1'b1;
    base = log_q.size();
    for (int i = 0; i < 6; i++) wr(8'h61 + 8'(i));
    chk("t5_pre", count, 5'd5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_count", count, 5'd0);
    chk("t5_empty", empty, 1'b1);
    tick(30);
    chk("t5_logn", log_q.size(), base + 1);
    if (log_q.size() > base) chk("t5_logd", log_q[base], 8'h61);

    // asynchronous reset in the middle of a frame
    base = log_q.size();
    wr(8'h77);
    wr(8'h88);
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_data", tx_data, 8'h00);
    chk("t6_count", count, 5'd0);
    chk("t6_empty", empty, 1'b1);
    chk("t6_start", tx_start, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(12);
    wr(8'h99);
    tick(20);
    chk("t6_logn", log_q.size(), base + 2);
    if (log_q.size() >= base + 2) begin
      chk("t6_first", log_q[base], 8'h77);
      chk("t6_next", log_q[base+1], 8'h99);
    end

    chk("edge_rules", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit-side byte buffer and launch controller that sits directly upstream of the UART transmitter. It accepts bytes from the host logic through a simple write strobe, stores them in a DEPTH-entry FIFO, and hands them one at a time to the transmitter over its `data_in` / `tx_start` / `tx_busy` handshake. It guarantees a clean rising edge on `tx_start` for every byte, which the transmitter requires, and it never drops a byte once the byte has been accepted.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `ACK_TIMEOUT`, 15: cycles to wait for `tx_busy` after a launch before re-launching the same byte.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `wr_en`  in  1  write strobe from host, one byte per cycle.
- `wr_data`  in  8  byte to enqueue.
- `flush`  in  1  synchronous clear of queued (not in-flight) bytes.
- `clr_ovf`  in  1  clears `overflow`.
- `tx_busy`  in  1  transmitter busy, from the transmitter.
- `tx_data`  out  8  byte presented to the transmitter's `data_in`.
- `tx_start`  out  1  launch pulse to the transmitter's `tx_start`.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `count`  out  log2(DEPTH)+1  bytes queued, excluding the in-flight byte.
- `overflow`  out  1  sticky; set when a write is dropped.
- `retry`  out  1  one-cycle pulse on each timeout re-launch.

## Operation
- Storage: circular buffer with `rd_ptr`/`wr_ptr` of log2(DEPTH) bits that wrap naturally, plus a registered `count`.
- Write: accepted when `wr_en && !full`. On accept, `mem[wr_ptr] <= wr_data`, `wr_ptr++`, `count++`. If `wr_en && full`, the byte is dropped and `overflow <= 1`.
- Full is evaluated on the registered count. A write while full is rejected even if a pop happens in the same cycle.
- Write and pop in the same cycle: the count is unchanged. A write into an empty FIFO is not bypassed; it can be popped at the earliest on the next cycle.
- FSM states:
  - IDLE: if `!empty && !tx_busy`, pop: `tx_data <= mem[rd_ptr]`, `rd_ptr++`, `count--`, then go to LAUNCH.
  - LAUNCH: drive `tx_start=1` for exactly one cycle, clear the timeout counter, then go to WAIT_BUSY.
  - WAIT_BUSY: `tx_start=0`. If `tx_busy`, go to WAIT_DONE. Otherwise, once the timeout counter reaches ACK_TIMEOUT, pulse `retry` and go to GAP. The byte is kept and re-launched.
  - WAIT_DONE: hold `tx_data`. On `!tx_busy`, go to GAP.
  - GAP: hold `tx_start=0` for one cycle while the transmitter is idle, so that its edge detector sees a low level. Then go to IDLE.
- `tx_data` is stable from the pop cycle until the next pop.
- `flush`: resets `rd_ptr`, `wr_ptr` and `count` to 0 and clears any write in the same cycle (flush wins). It does not affect the FSM or the in-flight byte.
- `clr_ovf`: clears `overflow`. If an overflow occurs in the same cycle, set wins.
- Illegal FSM encoding: return to IDLE with `tx_start=0`.

## Timing
- Reset values: `tx_data=0`, `tx_start=0`, `full=0`, `empty=1`, `count=0`, `overflow=0`, `retry=0`, FSM=IDLE. All outputs are registered.
- Reset mid-transfer: queued bytes are lost and `tx_start` drops to 0 immediately.
- Latency:
  - A write in cycle N is visible in `count`/`empty` at N+1.
  - With the transmitter idle, the pop happens at N+1 and `tx_start` is high at N+2.
- Transmitter response: `tx_busy` rises one cycle after the transmitter samples `tx_start`, so WAIT_BUSY normally lasts 1–2 cycles.
- Minimum spacing between consecutive `tx_start` pulses is LAUNCH + WAIT_BUSY + WAIT_DONE + GAP + IDLE, i.e. at least 5 cycles. In practice the spacing is dominated by the frame time.
- `tx_start` is never high in two consecutive cycles.
- `tx_start` is always preceded by at least one low cycle in which `tx_busy=0`.

## Test plan
- Reset then write 0xA5. Required: `tx_start` pulses 2 cycles after `wr_en`, `tx_data`=0xA5, and `count` returns to 0.
- Write 0x01..0x10 back-to-back with DEPTH=16 while the transmitter is busy. Required: `full=1` at count 16, a 17th write sets `overflow`, the dropped byte never appears, and output order is 0x01..0x10.
- Back-to-back frames with a transmitter model. Required: each byte produces exactly one `tx_start` rising edge, there is a low `tx_start` cycle with `tx_busy=0` before each pulse, and no byte is lost or duplicated.
- Hold `tx_busy=0` after a launch for more than ACK_TIMEOUT cycles. Required: `retry` pulses and the same byte is re-launched with an unchanged `tx_data`.
- Assert `flush` with 5 bytes queued and one in flight. Required: the in-flight byte completes, `count=0`, `empty=1`, and no further launches occur.
- Apply a `rst_n` low pulse during WAIT_DONE. Required: all outputs return to their reset values asynchronously, and the next write is transmitted normally.
